// File: rtl/kairo_decode_pkg.sv
// Shared types for the Kairo decode stage: encoded ops, opcodes, decode record.
package kairo_decode_pkg;

  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_FENCE, OP_FENCEI, OP_ECALL, OP_EBREAK, OP_MRET,
    OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
    OP_ILL = 6'h3F
  } op_e;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } buf_st_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [11:0] csr;
    logic        ill;
  } dec_t;

  localparam dec_t DEC_RST = '{op: OP_ILL, rd: '0, rs1: '0, rs2: '0, imm: '0, csr: '0, ill: 1'b0};

endpackage

// File: rtl/kairo_decode_stage_if.sv
// Fetch/execute-facing handshake bundle for the decode stage.
interface kairo_decode_stage_if #(
  parameter int unsigned PC_W = 32
);
  logic            FLUSH;
  logic            IN_VALID;
  logic            IN_READY;
  logic [PC_W-1:0] IN_PC;
  logic [31:0]     IN_INST;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [PC_W-1:0] OUT_PC;
  logic [5:0]      OUT_OP;
  logic [4:0]      OUT_RD;
  logic [4:0]      OUT_RS1;
  logic [4:0]      OUT_RS2;
  logic [31:0]     OUT_IMM;
  logic            OUT_ILL;
  logic [11:0]     OUT_CSR;

  modport master (
    output FLUSH, IN_VALID, IN_PC, IN_INST, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_PC, OUT_OP, OUT_RD, OUT_RS1, OUT_RS2,
           OUT_IMM, OUT_ILL, OUT_CSR
  );

  modport slave (
    input  FLUSH, IN_VALID, IN_PC, IN_INST, OUT_READY,
    output IN_READY, OUT_VALID, OUT_PC, OUT_OP, OUT_RD, OUT_RS1, OUT_RS2,
           OUT_IMM, OUT_ILL, OUT_CSR
  );
endinterface

// File: rtl/kairo_decode_core.sv
// Combinational RV32I(+M,+Zicsr) decoder: raw instruction word -> dec_t.
module kairo_decode_core
  import kairo_decode_pkg::*;
#(
  parameter bit EN_M      = 1'b1,
  parameter bit EN_CSR    = 1'b1,
  parameter bit EN_FENCEI = 1'b1
) (
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'h000};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  op_e         op;
  logic        use_rd, use_rs1, use_rs2, ill;
  logic [31:0] imm;
  logic [11:0] csr;

  // Classify the instruction; any path that leaves op at OP_ILL marks it illegal.
  always_comb begin
    op      = OP_ILL;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm     = '0;
    csr     = '0;
    if (inst[1:0] == 2'b11) begin
      case (opc)
        OPC_LUI:   begin op = OP_LUI;   use_rd = 1'b1; imm = imm_u; end
        OPC_AUIPC: begin op = OP_AUIPC; use_rd = 1'b1; imm = imm_u; end
        OPC_JAL:   begin op = OP_JAL;   use_rd = 1'b1; imm = imm_j; end
        OPC_JALR: begin
          if (f3 == 3'b000) op = OP_JALR;
          use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
        end
        OPC_BRANCH: begin
          case (f3)
            3'b000:  op = OP_BEQ;
            3'b001:  op = OP_BNE;
            3'b100:  op = OP_BLT;
            3'b101:  op = OP_BGE;
            3'b110:  op = OP_BLTU;
            3'b111:  op = OP_BGEU;
            default: op = OP_ILL;
          endcase
          use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b;
        end
        OPC_LOAD: begin
          case (f3)
            3'b000:  op = OP_LB;
            3'b001:  op = OP_LH;
            3'b010:  op = OP_LW;
            3'b100:  op = OP_LBU;
            3'b101:  op = OP_LHU;
            default: op = OP_ILL;
          endcase
          use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
        end
        OPC_STORE: begin
          case (f3)
            3'b000:  op = OP_SB;
            3'b001:  op = OP_SH;
            3'b010:  op = OP_SW;
            default: op = OP_ILL;
          endcase
          use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s;
        end
        OPC_OP_IMM: begin
          case (f3)
            3'b000:  op = OP_ADDI;
            3'b010:  op = OP_SLTI;
            3'b011:  op = OP_SLTIU;
            3'b100:  op = OP_XORI;
            3'b110:  op = OP_ORI;
            3'b111:  op = OP_ANDI;
            3'b001:  op = (f7 == F7_ZERO) ? OP_SLLI : OP_ILL;
            default: op = (f7 == F7_ZERO) ? OP_SRLI : ((f7 == F7_ALT) ? OP_SRAI : OP_ILL);
          endcase
          use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
        end
        OPC_OP: begin
          if (f7 == F7_ZERO) begin
            case (f3)
              3'b000:  op = OP_ADD;
              3'b001:  op = OP_SLL;
              3'b010:  op = OP_SLT;
              3'b011:  op = OP_SLTU;
              3'b100:  op = OP_XOR;
              3'b101:  op = OP_SRL;
              3'b110:  op = OP_OR;
              default: op = OP_AND;
            endcase
          end else if (f7 == F7_ALT) begin
            case (f3)
              3'b000:  op = OP_SUB;
              3'b101:  op = OP_SRA;
              default: op = OP_ILL;
            endcase
          end else if ((f7 == F7_MULDIV) && EN_M) begin
            case (f3)
              3'b000:  op = OP_MUL;
              3'b001:  op = OP_MULH;
              3'b010:  op = OP_MULHSU;
              3'b011:  op = OP_MULHU;
              3'b100:  op = OP_DIV;
              3'b101:  op = OP_DIVU;
              3'b110:  op = OP_REM;
              default: op = OP_REMU;
            endcase
          end
          use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
        OPC_MISC_MEM: begin
          if (f3 == 3'b000) begin
            op = OP_FENCE; use_rs1 = 1'b1;
          end else if ((f3 == 3'b001) && EN_FENCEI) begin
            op = OP_FENCEI; use_rd = 1'b1; use_rs1 = 1'b1;
          end
          imm = imm_i;
        end
        OPC_SYSTEM: begin
          if (EN_CSR) begin
            case (f3)
              3'b000: begin
                case (inst[31:20])
                  12'h000: op = OP_ECALL;
                  12'h001: op = OP_EBREAK;
                  12'h302: op = OP_MRET;
                  default: op = OP_ILL;
                endcase
                use_rs1 = 1'b1;
              end
              3'b001:  begin op = OP_CSRRW;  use_rd = 1'b1; use_rs1 = 1'b1; csr = inst[31:20]; end
              3'b010:  begin op = OP_CSRRS;  use_rd = 1'b1; use_rs1 = 1'b1; csr = inst[31:20]; end
              3'b011:  begin op = OP_CSRRC;  use_rd = 1'b1; use_rs1 = 1'b1; csr = inst[31:20]; end
              3'b101:  begin op = OP_CSRRWI; use_rd = 1'b1; imm = {27'd0, inst[19:15]}; csr = inst[31:20]; end
              3'b110:  begin op = OP_CSRRSI; use_rd = 1'b1; imm = {27'd0, inst[19:15]}; csr = inst[31:20]; end
              3'b111:  begin op = OP_CSRRCI; use_rd = 1'b1; imm = {27'd0, inst[19:15]}; csr = inst[31:20]; end
              default: op = OP_ILL;
            endcase
          end
        end
        default: op = OP_ILL;
      endcase
    end
    ill = (op == OP_ILL);
  end

  assign dec.op  = op;
  assign dec.ill = ill;
  assign dec.rd  = (use_rd  && !ill) ? inst[11:7]  : '0;
  assign dec.rs1 = (use_rs1 && !ill) ? inst[19:15] : '0;
  assign dec.rs2 = (use_rs2 && !ill) ? inst[24:20] : '0;
  assign dec.imm = ill ? '0 : imm;
  assign dec.csr = ill ? '0 : csr;

endmodule

// File: rtl/kairo_decode_stage.sv
// Decode pipeline stage: combinational decode into a 2-entry (head + skid) elastic buffer.
module kairo_decode_stage
  import kairo_decode_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter bit          EN_M      = 1'b1,
  parameter bit          EN_CSR    = 1'b1,
  parameter bit          EN_FENCEI = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [PC_W-1:0] IN_PC,
  input  logic [31:0]     IN_INST,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [PC_W-1:0] OUT_PC,
  output logic [5:0]      OUT_OP,
  output logic [4:0]      OUT_RD,
  output logic [4:0]      OUT_RS1,
  output logic [4:0]      OUT_RS2,
  output logic [31:0]     OUT_IMM,
  output logic            OUT_ILL,
  output logic [11:0]     OUT_CSR
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    dec_t            dec;
  } entry_t;

  localparam entry_t ENTRY_RST = '{pc: '0, dec: DEC_RST};

  buf_st_e state_q, state_d;
  entry_t  head_q, head_d, skid_q, skid_d, in_entry;
  dec_t    in_dec;
  logic    accept, pop;

  kairo_decode_core #(
    .EN_M      (EN_M),
    .EN_CSR    (EN_CSR),
    .EN_FENCEI (EN_FENCEI)
  ) u_core (
    .inst (IN_INST),
    .dec  (in_dec)
  );

  assign in_entry  = '{pc: IN_PC, dec: in_dec};
  assign IN_READY  = (state_q != BUF_FULL);
  assign OUT_VALID = (state_q != BUF_EMPTY);
  assign accept    = IN_VALID & IN_READY & ~FLUSH;
  assign pop       = OUT_VALID & OUT_READY;

  // Occupancy and entry movement; flush overrides everything and leaves data stale but invalid.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (FLUSH) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            head_d  = in_entry;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          case ({accept, pop})
            2'b10: begin skid_d = in_entry; state_d = BUF_FULL; end
            2'b01: state_d = BUF_EMPTY;
            2'b11: head_d = in_entry;
            default: ;
          endcase
        end
        BUF_FULL: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // Buffer registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= BUF_EMPTY;
      head_q  <= ENTRY_RST;
      skid_q  <= ENTRY_RST;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign OUT_PC  = head_q.pc;
  assign OUT_OP  = head_q.dec.op;
  assign OUT_RD  = head_q.dec.rd;
  assign OUT_RS1 = head_q.dec.rs1;
  assign OUT_RS2 = head_q.dec.rs2;
  assign OUT_IMM = head_q.dec.imm;
  assign OUT_ILL = head_q.dec.ill;
  assign OUT_CSR = head_q.dec.csr;

endmodule

// File: tb/tb_kairo_decode_stage.sv
// Scoreboard bench for kairo_decode_stage: one full-featured instance and one with EN_M=0 share stimulus.
module tb_kairo_decode_stage;
  import kairo_decode_pkg::*;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  kairo_decode_stage_if #(.PC_W(32)) ifc ();

  logic        b_in_ready, b_out_valid, b_ill;
  logic [31:0] b_pc, b_imm;
  logic [5:0]  b_op;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [11:0] b_csr;

  always #5 CLK = ~CLK;

  kairo_decode_stage #(.PC_W(32), .EN_M(1'b1), .EN_CSR(1'b1), .EN_FENCEI(1'b1)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(ifc.FLUSH),
    .IN_VALID(ifc.IN_VALID), .IN_READY(ifc.IN_READY), .IN_PC(ifc.IN_PC), .IN_INST(ifc.IN_INST),
    .OUT_VALID(ifc.OUT_VALID), .OUT_READY(ifc.OUT_READY), .OUT_PC(ifc.OUT_PC), .OUT_OP(ifc.OUT_OP),
    .OUT_RD(ifc.OUT_RD), .OUT_RS1(ifc.OUT_RS1), .OUT_RS2(ifc.OUT_RS2), .OUT_IMM(ifc.OUT_IMM),
    .OUT_ILL(ifc.OUT_ILL), .OUT_CSR(ifc.OUT_CSR)
  );

  kairo_decode_stage #(.PC_W(32), .EN_M(1'b0), .EN_CSR(1'b1), .EN_FENCEI(1'b1)) u_dut_nom (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(ifc.FLUSH),
    .IN_VALID(ifc.IN_VALID), .IN_READY(b_in_ready), .IN_PC(ifc.IN_PC), .IN_INST(ifc.IN_INST),
    .OUT_VALID(b_out_valid), .OUT_READY(ifc.OUT_READY), .OUT_PC(b_pc), .OUT_OP(b_op),
    .OUT_RD(b_rd), .OUT_RS1(b_rs1), .OUT_RS2(b_rs2), .OUT_IMM(b_imm),
    .OUT_ILL(b_ill), .OUT_CSR(b_csr)
  );

  typedef struct {
    logic [31:0] pc;
    dec_t        a;
    dec_t        b;
  } sb_t;

  sb_t         sb_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic dec_t mk(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic [11:0] csr);
    dec_t d;
    d.op  = op;
    d.rd  = rd;
    d.rs1 = rs1;
    d.rs2 = rs2;
    d.imm = imm;
    d.csr = csr;
    d.ill = (op == OP_ILL);
    return d;
  endfunction

  function automatic dec_t ill_d();
    return mk(OP_ILL, 5'd0, 5'd0, 5'd0, 32'd0, 12'd0);
  endfunction

  task automatic cmp_dec(input string tag, input dec_t e, input logic [5:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                         input logic [11:0] csr, input logic ill);
    chk({tag, ".op"},  64'(op),  64'(e.op));
    chk({tag, ".rd"},  64'(rd),  64'(e.rd));
    chk({tag, ".rs1"}, 64'(rs1), 64'(e.rs1));
    chk({tag, ".rs2"}, 64'(rs2), 64'(e.rs2));
    chk({tag, ".imm"}, 64'(imm), 64'(e.imm));
    chk({tag, ".csr"}, 64'(csr), 64'(e.csr));
    chk({tag, ".ill"}, 64'(ill), 64'(e.ill));
  endtask

  // Monitor: every consumed output entry is checked against the oldest expected entry.
  always @(negedge CLK) begin
    if (RST_N && ifc.OUT_VALID && ifc.OUT_READY) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc 0x%0h required no output", ifc.OUT_PC);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("a.pc", 64'(ifc.OUT_PC), 64'(e.pc));
        cmp_dec("a", e.a, ifc.OUT_OP, ifc.OUT_RD, ifc.OUT_RS1, ifc.OUT_RS2, ifc.OUT_IMM,
                ifc.OUT_CSR, ifc.OUT_ILL);
        chk("b.valid", 64'(b_out_valid), 64'd1);
        chk("b.pc", 64'(b_pc), 64'(e.pc));
        cmp_dec("b", e.b, b_op, b_rd, b_rs1, b_rs2, b_imm, b_csr, b_ill);
      end
    end
  end

  // Offer one instruction; the expected record is queued at the moment it is accepted.
  task automatic send(input logic [31:0] pc, input logic [31:0] inst, input dec_t ea, input dec_t eb);
    int unsigned n;
    sb_t s;
    ifc.IN_VALID = 1'b1;
    ifc.IN_PC    = pc;
    ifc.IN_INST  = inst;
    n = 0;
    @(negedge CLK);
    while (!ifc.IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!ifc.IN_READY) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: IN_READY stayed 0 for pc 0x%0h, required 1", pc);
    end else begin
      s.pc = pc;
      s.a  = ea;
      s.b  = eb;
      sb_q.push_back(s);
    end
    @(posedge CLK);
    #1;
    ifc.IN_VALID = 1'b0;
  endtask

  task automatic send_same(input logic [31:0] pc, input logic [31:0] inst, input dec_t e);
    send(pc, inst, e, e);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_left", 64'(sb_q.size()), 64'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    ifc.FLUSH     = 1'b0;
    ifc.IN_VALID  = 1'b0;
    ifc.IN_PC     = '0;
    ifc.IN_INST   = '0;
    ifc.OUT_READY = 1'b1;

    // Reset state
    #12;
    chk("rst.out_valid", 64'(ifc.OUT_VALID), 64'd0);
    chk("rst.in_ready",  64'(ifc.IN_READY),  64'd1);
    chk("rst.op",        64'(ifc.OUT_OP),    64'(OP_ILL));
    chk("rst.pc",        64'(ifc.OUT_PC),    64'd0);
    chk("rst.imm",       64'(ifc.OUT_IMM),   64'd0);
    chk("rst.ill",       64'(ifc.OUT_ILL),   64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // First instruction and its one-cycle latency
    send_same(32'h100, 32'h00500093, mk(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 12'd0));
    chk("lat.out_valid", 64'(ifc.OUT_VALID), 64'd1);
    chk("lat.out_pc",    64'(ifc.OUT_PC),    64'h100);

    // Decode vectors streamed back to back
    send_same(32'h104, 32'hFE208EE3, mk(OP_BEQ,    5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 12'd0));
    send_same(32'h108, 32'h123452B7, mk(OP_LUI,    5'd5, 5'd0, 5'd0, 32'h12345000, 12'd0));
    send     (32'h10C, 32'h022081B3, mk(OP_MUL,    5'd3, 5'd1, 5'd2, 32'd0, 12'd0), ill_d());
    send     (32'h110, 32'h027342B3, mk(OP_DIV,    5'd5, 5'd6, 5'd7, 32'd0, 12'd0), ill_d());
    send_same(32'h114, 32'h00000000, ill_d());
    send_same(32'h118, 32'h0020A423, mk(OP_SW,     5'd0, 5'd1, 5'd2, 32'd8, 12'd0));
    send_same(32'h11C, 32'h008000EF, mk(OP_JAL,    5'd1, 5'd0, 5'd0, 32'd8, 12'd0));
    send_same(32'h120, 32'h3003D2F3, mk(OP_CSRRWI, 5'd5, 5'd0, 5'd0, 32'd7, 12'h300));
    send_same(32'h124, 32'h02109093, ill_d());
    send_same(32'h128, 32'h4041D113, mk(OP_SRAI,   5'd2, 5'd3, 5'd0, 32'h404, 12'd0));
    send_same(32'h12C, 32'h00000073, mk(OP_ECALL,  5'd0, 5'd0, 5'd0, 32'd0, 12'd0));
    send_same(32'h130, 32'h10500073, ill_d());
    send_same(32'h134, 32'h402081B3, mk(OP_SUB,    5'd3, 5'd1, 5'd2, 32'd0, 12'd0));
    send_same(32'h138, 32'h00500090, ill_d());
    send_same(32'h13C, 32'h30200073, mk(OP_MRET,   5'd0, 5'd0, 5'd0, 32'd0, 12'd0));
    drain();

    // Backpressure: buffer fills, head holds, then A/B/C emerge in order
    ifc.OUT_READY = 1'b0;
    send_same(32'h200, 32'h00100513, mk(OP_ADDI, 5'd10, 5'd0, 5'd0, 32'd1, 12'd0));
    send_same(32'h204, 32'h00200593, mk(OP_ADDI, 5'd11, 5'd0, 5'd0, 32'd2, 12'd0));
    chk("full.in_ready",   64'(ifc.IN_READY), 64'd0);
    chk("full.b_in_ready", 64'(b_in_ready),   64'd0);
    fork
      send_same(32'h208, 32'h00300613, mk(OP_ADDI, 5'd12, 5'd0, 5'd0, 32'd3, 12'd0));
      begin
        repeat (3) begin
          @(negedge CLK);
          chk("hold.in_ready", 64'(ifc.IN_READY), 64'd0);
          chk("hold.pc",       64'(ifc.OUT_PC),   64'h200);
          chk("hold.rd",       64'(ifc.OUT_RD),   64'd10);
          chk("hold.imm",      64'(ifc.OUT_IMM),  64'd1);
        end
        @(posedge CLK);
        #1;
        ifc.OUT_READY = 1'b1;
      end
    join
    drain();

    // Flush with two entries held and an input offered
    ifc.OUT_READY = 1'b0;
    send_same(32'h300, 32'h00400693, mk(OP_ADDI, 5'd13, 5'd0, 5'd0, 32'd4, 12'd0));
    send_same(32'h304, 32'h00500713, mk(OP_ADDI, 5'd14, 5'd0, 5'd0, 32'd5, 12'd0));
    ifc.FLUSH    = 1'b1;
    ifc.IN_VALID = 1'b1;
    ifc.IN_PC    = 32'h308;
    ifc.IN_INST  = 32'h00600793;
    @(posedge CLK);
    #1;
    ifc.FLUSH    = 1'b0;
    ifc.IN_VALID = 1'b0;
    sb_q.delete();
    chk("flush2.out_valid", 64'(ifc.OUT_VALID), 64'd0);
    chk("flush2.in_ready",  64'(ifc.IN_READY),  64'd1);
    chk("flush2.b_valid",   64'(b_out_valid),   64'd0);

    // Flush with one entry held while the input would otherwise be accepted
    send_same(32'h600, 32'h00B00A13, mk(OP_ADDI, 5'd20, 5'd0, 5'd0, 32'd11, 12'd0));
    ifc.FLUSH    = 1'b1;
    ifc.IN_VALID = 1'b1;
    ifc.IN_PC    = 32'h604;
    ifc.IN_INST  = 32'h00C00A93;
    @(posedge CLK);
    #1;
    ifc.FLUSH    = 1'b0;
    ifc.IN_VALID = 1'b0;
    sb_q.delete();
    chk("flush1.out_valid", 64'(ifc.OUT_VALID), 64'd0);
    @(posedge CLK);
    #1;
    chk("flush1.still_empty", 64'(ifc.OUT_VALID), 64'd0);
    ifc.OUT_READY = 1'b1;
    send_same(32'h30C, 32'h00700813, mk(OP_ADDI, 5'd16, 5'd0, 5'd0, 32'd7, 12'd0));
    drain();

    // Asynchronous reset with a full buffer
    ifc.OUT_READY = 1'b0;
    send_same(32'h400, 32'h00800893, mk(OP_ADDI, 5'd17, 5'd0, 5'd0, 32'd8, 12'd0));
    send_same(32'h404, 32'h00900913, mk(OP_ADDI, 5'd18, 5'd0, 5'd0, 32'd9, 12'd0));
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst.out_valid", 64'(ifc.OUT_VALID), 64'd0);
    chk("arst.in_ready",  64'(ifc.IN_READY),  64'd1);
    chk("arst.op",        64'(ifc.OUT_OP),    64'(OP_ILL));
    sb_q.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    ifc.OUT_READY = 1'b1;
    send_same(32'h500, 32'h00A00993, mk(OP_ADDI, 5'd19, 5'd0, 5'd0, 32'd10, 12'd0));
    chk("arst_lat.out_valid", 64'(ifc.OUT_VALID), 64'd1);
    chk("arst_lat.out_pc",    64'(ifc.OUT_PC),    64'h500);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kairo_decode_stage.md
Name: kairo_decode_stage

Overview:
Parametrised RV32I(+M, +Zicsr) decode pipeline stage. It sits between the fetch and execute stages. Each instruction is fully decoded in a combinational core, producing a single enumerated opcode, register numbers, the immediate and an illegal flag. The result is registered into a 2-entry elastic output buffer with valid/ready on both sides and a synchronous flush. This replaces the flat per-instruction strobe outputs with one encoded op, so that execute-side muxing scales.

Parameters:
PC_W, 32, width of the PC carried alongside each instruction
EN_M, 1, 1 = M-extension ops are legal; 0 = MUL..REMU decode as illegal
EN_CSR, 1, 1 = CSRRW..CSRRCI, ECALL, EBREAK and MRET are legal; 0 = all of these decode as illegal
EN_FENCEI, 1, 1 = FENCE.I is legal; 0 = FENCE.I decodes as illegal

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST_N  in  1  asynchronous, active-low reset
FLUSH  in  1  drop all buffered entries and any input this cycle
IN_VALID  in  1  fetch offers an instruction
IN_READY  out  1  stage can accept an instruction
IN_PC  in  PC_W  PC of the offered instruction
IN_INST  in  32  raw instruction word
OUT_VALID  out  1  decoded entry available
OUT_READY  in  1  execute consumes the entry
OUT_PC  out  PC_W  PC of the entry
OUT_OP  out  6  op_e code (OP_ILL when illegal)
OUT_RD  out  5  destination register; 0 if the op has none
OUT_RS1  out  5  source register 1; 0 if unused
OUT_RS2  out  5  source register 2; 0 if unused
OUT_IMM  out  32  sign/zero-formed immediate; 0 for R-type and illegal
OUT_ILL  out  1  entry is an illegal instruction
OUT_CSR  out  12  inst[31:20] for CSR ops, else 0

Behaviour:
- Handshakes: accept = IN_VALID & IN_READY & ~FLUSH; pop = OUT_VALID & OUT_READY.
- Buffer: 2-entry FIFO, head and skid. count is in {0,1,2}.
- IN_READY = (count != 2). It is derived from registered state only and never depends on OUT_READY or FLUSH.
- OUT_VALID = (count != 0). All OUT_* fields come from the head register.
- Latency: an instruction accepted in cycle N is visible at the outputs in cycle N+1.
- Throughput: 1 instruction per cycle while OUT_READY=1.
- count transitions:
  - 0: accept -> 1
  - 1: accept & ~pop -> 2; pop & ~accept -> 0; accept & pop -> 1 (the new entry replaces the head)
  - 2: pop -> 1 (skid moves to head). No accept is possible.
- Ordering is strictly FIFO. Output fields must not change while OUT_VALID=1 and OUT_READY=0.
- FLUSH (synchronous):
  - next count = 0.
  - The input that cycle is dropped.
  - A pop in the same cycle still counts as consumed by execute, but has no other effect.
  - FLUSH has priority over accept and pop.
- Reset (async assert, sync deassert by design): count=0, OUT_VALID=0, all OUT_* data=0, OUT_OP=OP_ILL, IN_READY=1 after reset. Reset mid-stream discards all entries.
- Illegal detection, evaluated in the same cycle as the decode, not from prior-cycle strobes. An instruction is illegal if any of:
  - inst[1:0] != 2'b11
  - unknown opcode or funct3
  - funct7 not 0000000/0100000 where required
  - SLLI/SRLI/SRAI with inst[25]=1
  - SYSTEM funct3=000 with inst[31:20] not in {000, 001, 302}
  - SYSTEM funct3=100
  - the ops disabled by EN_M, EN_CSR or EN_FENCEI
- For an illegal entry: OUT_ILL=1, OP=OP_ILL, RD/RS1/RS2/IMM/CSR=0, PC preserved.
- Immediate formats:
  - I: sext inst[31:20]
  - S: sext {inst[31:25], inst[11:7]}
  - B: sext {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'h0}
  - J: sext {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - CSR immediate ops: IMM = zext inst[19:15] and RS1=0.
- Register fields: RD is zeroed for S/B/FENCE/ECALL/EBREAK/MRET. RS1 is zeroed for U/J. RS2 is zeroed for everything except R/S/B.

Decomposition:
- Package kairo_decode_pkg holds:
  - typedef enum logic [5:0] op_e: OP_LUI..OP_REMU in RV32IM order, OP_FENCE, OP_FENCEI, OP_ECALL, OP_EBREAK, OP_MRET, OP_CSRRW..OP_CSRRCI, OP_ILL = 6'h3F
  - opcode localparams (OPC_LOAD=7'b0000011, ...)
  - struct dec_t {op, rd, rs1, rs2, imm, csr, ill}
- Sub-module kairo_decode_core: purely combinational, parameters EN_M/EN_CSR/EN_FENCEI, maps inst -> dec_t.
- The stage module holds only the 2-entry buffer and the handshake logic.

Test Plan:
1. Reset release, then IN_INST=0x00500093 (addi x1,x0,5) at PC=0x100 with OUT_READY=1 -> next cycle OUT_VALID=1, OP_ADDI, RD=1, RS1=0, IMM=5, OUT_ILL=0, PC=0x100.
2. 0xFE208EE3 (beq x1,x2,-4) -> OP_BEQ, RD=0, RS1=1, RS2=2, IMM=0xFFFFFFFC. Then 0x123452B7 (lui x5) -> RD=5, RS1=0, IMM=0x12345000.
3. 0x022081B3 (mul x3,x1,x2): with EN_M=1 -> OP_MUL, RD=3. With EN_M=0 -> OUT_ILL=1, OP_ILL, RD=0. Also 0x00000000 -> illegal.
4. Back-to-back stream A,B,C with OUT_READY=0 -> IN_READY drops after 2 accepts, OUT fields hold A stably. Raise OUT_READY -> A, B, C emerge in order with no loss or duplicate.
5. count=2, assert FLUSH together with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, and the flushed input never appears at the output.
6. Assert RST_N=0 asynchronously mid-stream with count=2 -> OUT_VALID falls immediately without a clock edge. After release, the first new instruction emerges with 1-cycle latency.
